// File: rtl/booth_mult_ctrl_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier controller.
package booth_mult_ctrl_pkg;

    localparam int WIDTH = 32;
    localparam int ITERS = WIDTH / 2;
    localparam int ACC_W = WIDTH + 2;
    localparam int CNT_W = $clog2(ITERS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        P1   = 3'd1,
        P2   = 3'd2,
        M1   = 3'd3,
        M2   = 3'd4
    } digit_t;

    // Digit from the overlapping triplet {Q[1], Q[0], q_m1}.
    function automatic digit_t booth_decode(input logic [2:0] bits);
        case (bits)
            3'b001, 3'b010: booth_decode = P1;
            3'b011:         booth_decode = P2;
            3'b100:         booth_decode = M2;
            3'b101, 3'b110: booth_decode = M1;
            default:        booth_decode = ZERO;
        endcase
    endfunction

endpackage

// File: rtl/booth_mult_ctrl_if.sv
// Operand/result bundle between the execute stage and the multiply unit.
// The cancel wire exists only when BOOTH_CANCEL_EN is defined.
interface booth_mult_ctrl_if;
    import booth_mult_ctrl_pkg::*;

    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             result_rdy;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             overflow;
`ifdef BOOTH_CANCEL_EN
    logic             cancel;

    modport master (output start, op_a, op_b, cancel,
                    input  busy, result_rdy, result, result_hi, overflow);
    modport slave  (input  start, op_a, op_b, cancel,
                    output busy, result_rdy, result, result_hi, overflow);
`else
    modport master (output start, op_a, op_b,
                    input  busy, result_rdy, result, result_hi, overflow);
    modport slave  (input  start, op_a, op_b,
                    output busy, result_rdy, result, result_hi, overflow);
`endif

endinterface

// File: rtl/booth_step.sv
// One combinational radix-4 Booth iteration: digit decode, add/subtract into
// the 34-bit accumulator, then arithmetic shift of {acc, Q, q_m1} right by 2.
module booth_step
    import booth_mult_ctrl_pkg::*;
(
    input  logic [ACC_W-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic             q_m1,
    input  logic [ACC_W-1:0] m,
    output logic [ACC_W-1:0] acc_nxt,
    output logic [WIDTH-1:0] q_nxt,
    output logic             q_m1_nxt
);

    digit_t                    digit;
    logic [ACC_W-1:0]          sum;
    logic signed [ACC_W+WIDTH:0] shifted;

    always_comb begin
        digit = booth_decode({q[1:0], q_m1});
        sum   = acc;
        case (digit)
            P1:      sum = acc + m;
            P2:      sum = acc + (m << 1);
            M1:      sum = acc - m;
            M2:      sum = acc - (m << 1);
            default: sum = acc;
        endcase
        shifted  = $signed({sum, q, q_m1}) >>> 2;
        acc_nxt  = shifted[ACC_W+WIDTH:WIDTH+1];
        q_nxt    = shifted[WIDTH:1];
        q_m1_nxt = shifted[0];
    end

endmodule

// File: rtl/booth_mult_ctrl.sv
// Sequential 32x32 signed radix-4 Booth multiplier: FSM, step counter and
// result registers. Define BOOTH_CANCEL_EN to add the in-flight cancel input.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one Booth step per clock, 16 steps
// DONE  | result_rdy pulse; start here chains the next multiply
module booth_mult_ctrl
    import booth_mult_ctrl_pkg::*;
(
    input logic              clock,
    input logic              reset_n,
    booth_mult_ctrl_if.slave bus
);

    state_t             state, state_nxt;
    logic [ACC_W-1:0]   m, acc, acc_nxt;
    logic [WIDTH-1:0]   q, q_nxt;
    logic               q_m1, q_m1_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               abort, load, last;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH:0]     top_bits;
    logic [WIDTH-1:0]   res_lo, res_hi;
    logic               ovf;

`ifdef BOOTH_CANCEL_EN
    assign abort = bus.cancel;
`else
    assign abort = 1'b0;
`endif

    booth_step u_step (
        .acc      (acc),
        .q        (q),
        .q_m1     (q_m1),
        .m        (m),
        .acc_nxt  (acc_nxt),
        .q_nxt    (q_nxt),
        .q_m1_nxt (q_m1_nxt)
    );

    assign last     = (cnt == CNT_W'(ITERS - 1));
    // Product is captured straight from the final step's outputs.
    assign product  = {acc_nxt[WIDTH-1:0], q_nxt};
    assign top_bits = product[2*WIDTH-1:WIDTH-1];

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (abort)     state_nxt = IDLE;
                else if (last) state_nxt = DONE;
            end
            DONE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m      <= '0;
            acc    <= '0;
            q      <= '0;
            q_m1   <= 1'b0;
            cnt    <= '0;
            res_lo <= '0;
            res_hi <= '0;
            ovf    <= 1'b0;
        end else if (load) begin
            m    <= {{(ACC_W-WIDTH){bus.op_a[WIDTH-1]}}, bus.op_a};
            acc  <= '0;
            q    <= bus.op_b;
            q_m1 <= 1'b0;
            cnt  <= '0;
        end else if (state == RUN && !abort) begin
            acc  <= acc_nxt;
            q    <= q_nxt;
            q_m1 <= q_m1_nxt;
            cnt  <= cnt + 1'b1;
            if (last) begin
                res_lo <= product[WIDTH-1:0];
                res_hi <= product[2*WIDTH-1:WIDTH];
                ovf    <= ~(&top_bits | ~|top_bits);
            end
        end
    end

    assign bus.busy       = (state == RUN);
    assign bus.result_rdy = (state == DONE);
    assign bus.result     = res_lo;
    assign bus.result_hi  = res_hi;
    assign bus.overflow   = ovf;

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Self-checking bench for booth_mult_ctrl: directed corner cases plus
// randomized operands against a 64-bit integer-multiply reference.
module tb_booth_mult_ctrl;

    logic clock = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] exp_lo, exp_hi, pend_lo, pend_hi;
    logic        exp_ovf, pend_ovf;

    booth_mult_ctrl_if bus ();

    booth_mult_ctrl dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p        = longint'($signed(a)) * longint'($signed(b));
        pend_lo  = p[31:0];
        pend_hi  = p[63:32];
        pend_ovf = (p != longint'($signed(p[31:0])));
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] corner [5];
        int v;
        corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: begin
                v = int'($urandom_range(0, 200)) - 100;
                return 32'(v);
            end
            2: return corner[$urandom_range(0, 4)];
            default: return 32'h1 << $urandom_range(0, 31);
        endcase
    endfunction

    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        model(a, b);
        @(negedge clock);
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        chk("busy_after_start", 64'(bus.busy), 64'd1);
        chk("rdy_low_after_start", 64'(bus.result_rdy), 64'd0);
    endtask

    task automatic wait_done(input string tag, input int inject_at);
        int k;
        k = 0;
        while (k < 40) begin
            @(negedge clock);
            if (k + 1 == inject_at) begin
                bus.start = 1'b1;
                bus.op_a  = $urandom;
                bus.op_b  = $urandom;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clock);
            #1;
            k++;
            if (k == 8) begin
                chk({tag, "_hold_mid_run"}, {bus.result_hi, bus.result}, {exp_hi, exp_lo});
                chk({tag, "_busy_mid_run"}, 64'(bus.busy), 64'd1);
            end
            if (bus.result_rdy) break;
        end
        bus.start = 1'b0;
        exp_lo  = pend_lo;
        exp_hi  = pend_hi;
        exp_ovf = pend_ovf;
        chk({tag, "_latency"}, 64'(k), 64'd16);
        chk({tag, "_lo"}, 64'(bus.result), 64'(exp_lo));
        chk({tag, "_hi"}, 64'(bus.result_hi), 64'(exp_hi));
        chk({tag, "_ovf"}, 64'(bus.overflow), 64'(exp_ovf));
    endtask

    task automatic idle_cycle(input string tag);
        @(posedge clock);
        #1;
        chk({tag, "_rdy_one_cycle"}, 64'(bus.result_rdy), 64'd0);
        chk({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic watch_quiet(input string tag);
        int pulses;
        pulses = 0;
        repeat (24) begin
            @(posedge clock);
            #1;
            if (bus.result_rdy) pulses++;
        end
        chk({tag, "_no_rdy"}, 64'(pulses), 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_kept_lo"}, 64'(bus.result), 64'(exp_lo));
        chk({tag, "_kept_hi"}, 64'(bus.result_hi), 64'(exp_hi));
        chk({tag, "_kept_ovf"}, 64'(bus.overflow), 64'(exp_ovf));
    endtask

    initial begin
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
`ifdef BOOTH_CANCEL_EN
        bus.cancel = 1'b0;
`endif
        exp_lo  = '0;
        exp_hi  = '0;
        exp_ovf = 1'b0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_rdy", 64'(bus.result_rdy), 64'd0);
        chk("reset_out", {bus.result_hi, bus.result}, 64'd0);
        chk("reset_ovf", 64'(bus.overflow), 64'd0);

        launch(32'd3, 32'd5);
        wait_done("s2", 0);
        idle_cycle("s2");

        launch(-32'sd7, 32'd6);
        wait_done("s3", 0);
        idle_cycle("s3");

        launch(32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("s4", 0);
        idle_cycle("s4");

        launch(32'h0001_0000, 32'h0001_0000);
        wait_done("s5", 0);
        idle_cycle("s5");

        launch(32'h1234_5678, 32'hFEDC_BA98);
        wait_done("s6_ignored_start", 5);
        idle_cycle("s6");

        launch(32'h0, 32'h7FFF_FFFF);
        wait_done("zero_op", 0);
        launch(32'hFFFF_FFF0, 32'h8000_0000);
        wait_done("s7_back_to_back", 0);
        idle_cycle("s7");

        for (int i = 0; i < 24; i++) begin
            launch(pick(), pick());
            wait_done("rand", 0);
            if (i % 3 != 0) idle_cycle("rand");
        end

        launch(32'h0000_0101, 32'h0000_0202);
        repeat (7) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        exp_lo  = '0;
        exp_hi  = '0;
        exp_ovf = 1'b0;
        chk("s8_busy", 64'(bus.busy), 64'd0);
        chk("s8_out", {bus.result_hi, bus.result}, 64'd0);
        chk("s8_ovf", 64'(bus.overflow), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        watch_quiet("s8");

`ifdef BOOTH_CANCEL_EN
        launch(32'h0000_0011, 32'h0000_0022);
        wait_done("pre_cancel", 0);
        launch(32'h7777_0000, 32'h0000_1234);
        repeat (7) @(posedge clock);
        @(negedge clock);
        bus.cancel = 1'b1;
        @(posedge clock);
        #1;
        chk("s9_idle_after_cancel", 64'(bus.busy), 64'd0);
        chk("s9_no_rdy", 64'(bus.result_rdy), 64'd0);
        bus.cancel = 1'b0;
        watch_quiet("s9");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
